mult_hilo_ctrl: RTL and testbench
=================================

Name: mult_hilo_ctrl

Overview:
- Multi-cycle controller directly downstream of the combinational 32x32 unsigned multiplier (MULT32_U).
- Registers operand magnitudes onto the multiplier inputs and waits LATENCY cycles for the product to settle.
- Applies signed correction to the 64-bit {MUL_HI,MUL_LO} product and commits it to the architectural HI/LO registers.
- Also services MTHI/MTLO writes. It is the HI/LO back-end for MULT/MULTU in the processor datapath.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width (matches `DATA_INDEX_LIMIT`+1)
LATENCY, 2, cycles spent in WAIT before the product is sampled; legal range 1..15

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
START  input  1  request a multiply; sampled only in IDLE
SIGNED  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with START
OP_A  input  32  multiplicand
OP_B  input  32  multiplier
MUL_A  output  32  registered magnitude of OP_A, driven to MULT32_U A
MUL_B  output  32  registered magnitude of OP_B, driven to MULT32_U B
MUL_HI  input  32  MULT32_U HI result
MUL_LO  input  32  MULT32_U LO result
MTHI  input  1  write WDATA to HI
MTLO  input  1  write WDATA to LO
WDATA  input  32  move-to data
HI  output  32  architectural HI register
LO  output  32  architectural LO register
BUSY  output  1  high while in WAIT
DONE  output  1  one-cycle pulse, registered, on the cycle after HI/LO commit from a multiply

Behaviour:
- Reset on a rising edge with RST=1 sets state IDLE, cnt=0, neg=0, and MUL_A=MUL_B=HI=LO=0. BUSY=0 and DONE=0. RST overrides every other input, including mid-WAIT; an aborted multiply never pulses DONE.
- States: IDLE and WAIT. BUSY = (state==WAIT), decoded combinationally from the state register.
- IDLE with START=1, at the edge:
  - MUL_A <= (SIGNED & OP_A[31]) ? -OP_A : OP_A; MUL_B likewise for OP_B.
  - neg <= SIGNED & (OP_A[31]^OP_B[31]); cnt <= LATENCY-1; state <= WAIT.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- WAIT, at each edge:
  - If cnt!=0, cnt <= cnt-1.
  - If cnt==0, P = {MUL_HI,MUL_LO}; {HI,LO} <= neg ? (~P + 1) mod 2^64 : P; DONE <= 1; state <= IDLE.
- Timing: HI/LO are updated on the LATENCY-th rising edge after the edge that samples START. DONE is high for exactly the following cycle; DONE is cleared on every other edge.
- MUL_A/MUL_B hold their values after completion until the next START or RST.
- IDLE without START: MTHI=1 gives HI <= WDATA; MTLO=1 gives LO <= WDATA. Both may be asserted together, and both are written.
- Precedence in IDLE: START has priority over MTHI/MTLO in the same cycle; the move is dropped.
- While BUSY, START, MTHI and MTLO are ignored (dropped, not queued), and HI/LO hold their old values until commit.
- Back-to-back: START may be asserted in the cycle DONE is high, because the state is already IDLE.

Optional Feature:
- Macro: MULT_HILO_ACC_EN.
- When defined, adds input ACC (1 bit), sampled with START and held in a register.
  - At commit with acc=1: {HI,LO} <= {HI,LO} + signed-corrected product, mod 2^64 (MADD/MADDU).
  - At commit with acc=0: plain write, as in the base behaviour.
- When undefined, the ACC port and register are absent and commit is always a plain write.

Test Plan:
(Bench instantiates MULT32_U wired MUL_A/MUL_B -> A/B and HI/LO -> MUL_HI/MUL_LO; LATENCY=2.)
- Reset: RST=1 for 2 edges -> HI=LO=MUL_A=MUL_B=0, BUSY=0, DONE=0. Then RST=0 and idle 3 cycles -> all outputs unchanged.
- MULTU with OP_A=B=0xffffffff, START 1 cycle:
  - BUSY high for exactly 2 cycles.
  - At the 2nd edge: HI=0xfffffffe, LO=0x00000001.
  - DONE pulses 1 cycle.
- MULT with OP_A=0xffffffff, OP_B=0x00000001:
  - MUL_A=MUL_B=0x00000001 during WAIT.
  - Result HI=LO=0xffffffff.
  - Follow with MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- Moves and drops:
  - IDLE, MTHI=1, WDATA=0x12345678 -> next edge HI=0x12345678, LO unchanged.
  - START (1x1 MULTU) then, during BUSY, re-assert START with 5x5 and MTLO=1, WDATA=0xdeadbeef -> after commit HI=0, LO=1. Only one DONE pulse.
- Reset mid-op: START (0x0023df9b x 0x7ba01b1a unsigned), RST=1 on the first WAIT edge -> BUSY=0, HI=LO=0, no DONE within the next 5 cycles.
- With MULT_HILO_ACC_EN: HI=0, LO=5 via MTLO, then START ACC=1 MULTU 2x3 -> LO=0x0000000b, HI=0. Then ACC=1 MULT 0xffffffff x 1 -> LO=0x0000000a, HI=0.

Source files
------------

// File: rtl/mult_hilo_ctrl.sv
// HI/LO back-end for MULT/MULTU: drives operand magnitudes to an external 32x32
// unsigned multiplier, waits LATENCY cycles, then commits the sign-corrected product.
// Optional macro MULT_HILO_ACC_EN adds the ACC input for MADD/MADDU accumulation.
module mult_hilo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SIGNED,
`ifdef MULT_HILO_ACC_EN
  input  logic                  ACC,
`endif
  input  logic [DATA_WIDTH-1:0] OP_A,
  input  logic [DATA_WIDTH-1:0] OP_B,
  output logic [DATA_WIDTH-1:0] MUL_A,
  output logic [DATA_WIDTH-1:0] MUL_B,
  input  logic [DATA_WIDTH-1:0] MUL_HI,
  input  logic [DATA_WIDTH-1:0] MUL_LO,
  input  logic                  MTHI,
  input  logic                  MTLO,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int         PW       = 2 * DATA_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic [DATA_WIDTH-1:0] mul_a_q, mul_a_d;
  logic [DATA_WIDTH-1:0] mul_b_q, mul_b_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  done_q, done_d;
  logic [PW-1:0]         prod_s;
  logic [PW-1:0]         corr_s;
  logic [PW-1:0]         commit_s;
`ifdef MULT_HILO_ACC_EN
  logic                  acc_q, acc_d;
`endif

  // Two's-complement magnitude; 0x80000000 maps onto itself and is read as unsigned.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x,
                                                       input logic sgn);
    if (sgn && x[DATA_WIDTH-1]) begin
      magnitude = ~x + DATA_WIDTH'(1);
    end else begin
      magnitude = x;
    end
  endfunction

  // Sign correction of the unsigned product, plus optional accumulate into {HI,LO}.
  always_comb begin
    prod_s = {MUL_HI, MUL_LO};
    if (neg_q) begin
      corr_s = ~prod_s + PW'(1);
    end else begin
      corr_s = prod_s;
    end
`ifdef MULT_HILO_ACC_EN
    if (acc_q) begin
      commit_s = {hi_q, lo_q} + corr_s;
    end else begin
      commit_s = corr_s;
    end
`else
    commit_s = corr_s;
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULT_HILO_ACC_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        // START wins over a same-cycle move; the move is simply dropped.
        if (START) begin
          mul_a_d = magnitude(OP_A, SIGNED);
          mul_b_d = magnitude(OP_B, SIGNED);
          neg_d   = SIGNED & (OP_A[DATA_WIDTH-1] ^ OP_B[DATA_WIDTH-1]);
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
`ifdef MULT_HILO_ACC_EN
          acc_d   = ACC;
`endif
        end else begin
          if (MTHI) begin
            hi_d = WDATA;
          end else begin
            hi_d = hi_q;
          end
          if (MTLO) begin
            lo_d = WDATA;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          {hi_d, lo_d} = commit_s;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset also aborts an in-flight multiply without a DONE pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      neg_q   <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULT_HILO_ACC_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULT_HILO_ACC_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign MUL_A = mul_a_q;
  assign MUL_B = mul_b_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign DONE  = done_q;
  assign BUSY  = (state_q == S_WAIT);

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Self-checking bench for mult_hilo_ctrl with a behavioural 32x32 unsigned multiplier
// on MUL_A/MUL_B; commits are checked against a scoreboard on every DONE pulse.
module tb_mult_hilo_ctrl;
  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST, START, SIGNED, MTHI, MTLO;
  logic [31:0] OP_A, OP_B, WDATA;
  logic [31:0] MUL_A, MUL_B, MUL_HI, MUL_LO, HI, LO;
  logic        BUSY, DONE;
`ifdef MULT_HILO_ACC_EN
  logic        ACC;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [63:0] p;
  } vec_t;
  vec_t vecs[8];

  always #5 CLK = ~CLK;

  // stand-in for MULT32_U
  assign {MUL_HI, MUL_LO} = {32'd0, MUL_A} * {32'd0, MUL_B};

  mult_hilo_ctrl #(.DATA_WIDTH(32), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED),
`ifdef MULT_HILO_ACC_EN
    .ACC(ACC),
`endif
    .OP_A(OP_A), .OP_B(OP_B), .MUL_A(MUL_A), .MUL_B(MUL_B),
    .MUL_HI(MUL_HI), .MUL_LO(MUL_LO), .MTHI(MTHI), .MTLO(MTLO), .WDATA(WDATA),
    .HI(HI), .LO(LO), .BUSY(BUSY), .DONE(DONE)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every DONE pulse must match the oldest outstanding multiply.
  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("done_without_request", 64'(sb_q.size()), 64'd1);
      end else begin
        check("commit_hilo", {HI, LO}, sb_q.pop_front());
      end
    end
  end

  task automatic run_mult(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ea, input logic [31:0] eb, input logic [63:0] p);
    int busy_n;
    bit seen;
    START = 1'b1; SIGNED = sgn; OP_A = a; OP_B = b;
    sb_q.push_back(p);
    @(negedge CLK);
    START = 1'b0;
    check("mul_a", MUL_A, ea);
    check("mul_b", MUL_B, eb);
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (DONE === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (BUSY === 1'b1) busy_n++;
      @(negedge CLK);
    end
    check("done_seen", 64'(seen), 64'd1);
    check("busy_cycles", 64'(busy_n), 64'(LAT));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_hi"}, HI, 64'd0);
    check({tag, "_lo"}, LO, 64'd0);
    check({tag, "_mul_a"}, MUL_A, 64'd0);
    check({tag, "_mul_b"}, MUL_B, 64'd0);
    check({tag, "_busy"}, 64'(BUSY), 64'd0);
    check({tag, "_done"}, 64'(DONE), 64'd0);
  endtask

  initial begin
    int  done0;
    bit  seen;
    vecs[0] = '{1'b0, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 64'hfffffffe_00000001};
    vecs[1] = '{1'b1, 32'hffffffff, 32'h00000001, 32'h00000001, 32'h00000001, 64'hffffffff_ffffffff};
    vecs[2] = '{1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[3] = '{1'b1, 32'hfffffffe, 32'h00000003, 32'h00000002, 32'h00000003, 64'hffffffff_fffffffa};
    vecs[4] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 64'h00000001_00000000};
    vecs[5] = '{1'b1, 32'h00000007, 32'hfffffff9, 32'h00000007, 32'h00000007, 64'hffffffff_ffffffcf};
    vecs[6] = '{1'b0, 32'h80000000, 32'h00000002, 32'h80000000, 32'h00000002, 64'h00000001_00000000};
    vecs[7] = '{1'b1, 32'h00001234, 32'h00000010, 32'h00001234, 32'h00000010, 64'h00000000_00012340};

    RST = 1'b1; START = 1'b0; SIGNED = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
    OP_A = 32'd0; OP_B = 32'd0; WDATA = 32'd0;
`ifdef MULT_HILO_ACC_EN
    ACC = 1'b0;
`endif
    @(negedge CLK);
    @(negedge CLK);
    check_idle_zero("reset");
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle_zero("post_reset_idle");

    // Back-to-back: each new START is driven in the cycle DONE is high.
    for (int i = 0; i < 8; i++) begin
      run_mult(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].ea, vecs[i].eb, vecs[i].p);
    end
    @(negedge CLK);
    check("done_single_pulse", 64'(DONE), 64'd0);
    check("mul_a_hold", MUL_A, 64'h00001234);

    MTHI = 1'b1; WDATA = 32'h12345678;
    @(negedge CLK);
    MTHI = 1'b0;
    check("mthi_hi", HI, 64'h12345678);
    check("mthi_lo_unchanged", LO, 64'h00012340);
    MTHI = 1'b1; MTLO = 1'b1; WDATA = 32'ha5a5a5a5;
    @(negedge CLK);
    MTHI = 1'b0; MTLO = 1'b0;
    check("mt_both_hi", HI, 64'ha5a5a5a5);
    check("mt_both_lo", LO, 64'ha5a5a5a5);

    // START with a same-cycle MTLO, then START+MTLO again while busy: all dropped.
    done0 = n_done;
    START = 1'b1; SIGNED = 1'b0; OP_A = 32'd1; OP_B = 32'd1; MTLO = 1'b1; WDATA = 32'hcafef00d;
    sb_q.push_back(64'd1);
    @(negedge CLK);
    OP_A = 32'd5; OP_B = 32'd5; WDATA = 32'hdeadbeef;
    check("busy_hi_hold", HI, 64'ha5a5a5a5);
    check("busy_lo_hold", LO, 64'ha5a5a5a5);
    @(negedge CLK);
    START = 1'b0; MTLO = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (DONE === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check("drop_done_seen", 64'(seen), 64'd1);
    repeat (4) @(negedge CLK);
    check("drop_one_done", 64'(n_done - done0), 64'd1);
    check("drop_hi", HI, 64'd0);
    check("drop_lo", LO, 64'd1);
    check("drop_mul_a", MUL_A, 64'd1);

    // Reset on the first WAIT edge aborts without a DONE.
    START = 1'b1; SIGNED = 1'b0; OP_A = 32'h0023df9b; OP_B = 32'h7ba01b1a;
    @(negedge CLK);
    START = 1'b0;
    check("abort_busy_before", 64'(BUSY), 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_idle_zero("abort");
    done0 = n_done;
    repeat (5) @(negedge CLK);
    check("abort_no_done", 64'(n_done), 64'(done0));

`ifdef MULT_HILO_ACC_EN
    MTLO = 1'b1; WDATA = 32'd5;
    @(negedge CLK);
    MTLO = 1'b0;
    ACC = 1'b1;
    run_mult(1'b0, 32'd2, 32'd3, 32'd2, 32'd3, 64'd11);
    run_mult(1'b1, 32'hffffffff, 32'd1, 32'd1, 32'd1, 64'd10);
    ACC = 1'b0;
    @(negedge CLK);
    check("acc_lo", LO, 64'h0000000a);
    check("acc_hi", HI, 64'd0);
`endif

    @(negedge CLK);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
